// File: rtl/round_key_sequencer.sv
// round_key_sequencer: key bank streamed forward/reverse over valid/ready, one key per beat.
// Define RKS_PARITY_EN to store per-byte even parity and raise a sticky par_err_o on bad loads.
module round_key_sequencer #(
    parameter int DATA_W   = 128,
    parameter int NUM_KEYS = 11,
    parameter int IDX_W    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              start_i,
    input  logic              dir_i,
    input  logic              key_ready_i,
    output logic              key_valid_o,
    output logic [DATA_W-1:0] key_out_o,
    output logic [IDX_W-1:0]  key_idx_o,
    output logic              key_last_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              par_err_o
);
    localparam logic [IDX_W-1:0] TOP = IDX_W'(NUM_KEYS - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_q;
    logic [DATA_W-1:0] bank_q [NUM_KEYS];
    logic [DATA_W-1:0] key_q;
    logic [IDX_W-1:0]  idx_q, ld_idx_d;
    logic              valid_q, last_q, done_q, dir_q;
    logic              ld_en_d, ld_dir_d, ld_last_d, wr_ok;

    // A load happens on an accepted start or on a non-final beat; it snapshots the bank entry.
    always_comb begin
        ld_en_d   = (state_q == IDLE) ? start_i : (valid_q & key_ready_i & ~last_q);
        ld_dir_d  = (state_q == IDLE) ? dir_i : dir_q;
        ld_idx_d  = (state_q == IDLE) ? (dir_i ? TOP : '0) : (dir_q ? idx_q - 1'b1 : idx_q + 1'b1);
        ld_last_d = ld_idx_d == (ld_dir_d ? '0 : TOP);
    end

    assign wr_ok = wr_en_i && (32'(wr_idx_i) < NUM_KEYS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_KEYS; i++) bank_q[i] <= '0;
        end else if (wr_ok) begin
            bank_q[wr_idx_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            key_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            dir_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (ld_en_d) begin
                idx_q  <= ld_idx_d;
                key_q  <= bank_q[ld_idx_d];
                last_q <= ld_last_d;
            end
            if (state_q == IDLE) begin
                if (start_i) begin
                    state_q <= RUN;
                    dir_q   <= dir_i;
                    valid_q <= 1'b1;
                end
            end else if (key_ready_i && last_q) begin
                state_q <= IDLE;
                valid_q <= 1'b0;
                last_q  <= 1'b0;
                done_q  <= 1'b1;
            end
        end
    end

    assign key_valid_o = valid_q;
    assign key_out_o   = key_q;
    assign key_idx_o   = idx_q;
    assign key_last_o  = last_q;
    assign busy_o      = state_q == RUN;
    assign done_o      = done_q;

`ifdef RKS_PARITY_EN
    localparam int NB = DATA_W / 8;

    logic [NB-1:0] par_q [NUM_KEYS];
    logic          err_q;

    function automatic logic [NB-1:0] par_of(input logic [DATA_W-1:0] d);
        for (int b = 0; b < NB; b++) par_of[b] = ^d[8*b +: 8];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_KEYS; i++) par_q[i] <= '0;
            err_q <= 1'b0;
        end else begin
            if (wr_ok) par_q[wr_idx_i] <= par_of(wr_data_i);
            if (ld_en_d && par_of(bank_q[ld_idx_d]) != par_q[ld_idx_d]) err_q <= 1'b1;
        end
    end

    assign par_err_o = err_q;
`else
    assign par_err_o = 1'b0;
`endif
endmodule
